// File: rtl/diff_core_pkg.sv
// Shared types for the feature-map guard layer scheduler: the layer
// descriptor layout and the scheduler FSM state encoding.
package diff_core_pkg;

    localparam int DESC_W = 26;

    // Field order matches the packed config word {w,h,c,kernal_mode,bit_mode}.
    typedef struct packed {
        logic [7:0] w;
        logic [7:0] h;
        logic [7:0] c;
        logic       kernal_mode;
        logic       bit_mode;
    } layer_desc_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        RUN    = 3'd3,
        FINISH = 3'd4
    } sched_state_t;

endpackage

// File: rtl/fm_layer_desc_table.sv
// Layer descriptor table: flop array cleared by reset, one write port and
// one registered read port. The read register doubles as the descriptor
// output register of the scheduler, so it only updates on a read strobe.
module fm_layer_desc_table
    import diff_core_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int LW         = $clog2(MAX_LAYERS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [LW-1:0]     waddr,
    input  logic [DESC_W-1:0] wdata,
    input  logic              re,
    input  logic [LW-1:0]     raddr,
    output logic [DESC_W-1:0] rdata
);

    logic [DESC_W-1:0] mem [MAX_LAYERS];

    // Table storage: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read: holds the last fetched entry until the next read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fm_guard_layer_sched.sv
// Layer scheduler for the feature-map guard generator. Walks layers
// 0..num_layers-1 of the descriptor table: fetch a descriptor, offer it on
// the config handshake, then wait for the controller's layer-finish pulse.
//
// Handshake: ctrl_valid is a register. Once raised it stays high with the
// descriptor fields frozen until a cycle where ctrl_valid && ctrl_ready is
// sampled at the clock edge (the transfer), or an abort drops it. ctrl_valid
// never depends combinationally on ctrl_ready.
module fm_guard_layer_sched
    import diff_core_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int LW         = $clog2(MAX_LAYERS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [LW-1:0]     cfg_addr,
    input  logic [DESC_W-1:0] cfg_wdata,
    output logic              cfg_err,
    input  logic              start,
    input  logic [LW:0]       num_layers,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LW-1:0]     cur_layer,
    output logic              ctrl_valid,
    input  logic              ctrl_ready,
    input  logic              ctrl_finish,
    output logic [7:0]        w_num_o,
    output logic [7:0]        h_num_o,
    output logic [7:0]        c_num_o,
    output logic              kernal_mode_o,
    output logic              bit_mode_o,
    output logic [2:0]        dbg_state
);

    localparam logic [LW:0] MAX_CNT = (LW+1)'(MAX_LAYERS);

    sched_state_t      state, state_n;
    logic [LW:0]       num_q, num_n;
    logic [LW-1:0]     cur_q, cur_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              aborted_q, aborted_n;
    logic              cfg_err_q, cfg_err_n;
    logic              valid_q, valid_n;
    logic              pend_q, pend_n;
    logic              tbl_we;
    logic              rd_en;
    logic              last_layer;
    logic [LW:0]       num_clamped;
    logic [DESC_W-1:0] desc_bits;
    layer_desc_t       desc;

    fm_layer_desc_table #(
        .MAX_LAYERS (MAX_LAYERS),
        .LW         (LW)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .re    (rd_en),
        .raddr (cur_q),
        .rdata (desc_bits)
    );

    // Layer counts above the table depth run the whole table, which also
    // keeps the layer index from ever wrapping.
    assign num_clamped = (num_layers > MAX_CNT) ? MAX_CNT : num_layers;
    // num_q is at least 1 whenever RUN is reachable.
    assign last_layer  = ({1'b0, cur_q} == (num_q - (LW+1)'(1)));

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_n   = state;
        num_n     = num_q;
        cur_n     = cur_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        valid_n   = valid_q;
        pend_n    = pend_q;
        rd_en     = 1'b0;
        // Writes only land while idle; a write that lands with start is
        // visible to the first fetch.
        tbl_we    = cfg_we && (state == IDLE);
        cfg_err_n = cfg_we && (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    num_n   = num_clamped;
                    busy_n  = 1'b1;
                    cur_n   = '0;
                    pend_n  = 1'b0;
                    state_n = (num_clamped == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    aborted_n = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else begin
                    rd_en   = 1'b1;
                    valid_n = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // A completed transfer takes priority: an abort in the same
                // cycle is deferred as if it arrived during RUN.
                if (valid_q && ctrl_ready) begin
                    valid_n = 1'b0;
                    state_n = RUN;
                    if (abort) begin
                        pend_n = 1'b1;
                    end
                end else if (abort) begin
                    valid_n   = 1'b0;
                    aborted_n = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end
            end
            RUN: begin
                // The downstream layer cannot be cancelled, so an abort is
                // remembered and honoured when the layer finishes.
                if (abort) begin
                    pend_n = 1'b1;
                end
                if (ctrl_finish) begin
                    if (pend_q || abort) begin
                        aborted_n = 1'b1;
                        busy_n    = 1'b0;
                        pend_n    = 1'b0;
                        state_n   = IDLE;
                    end else if (last_layer) begin
                        state_n = FINISH;
                    end else begin
                        cur_n   = cur_q + LW'(1);
                        state_n = FETCH;
                    end
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            num_q     <= '0;
            cur_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
            valid_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state     <= state_n;
            num_q     <= num_n;
            cur_q     <= cur_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            aborted_q <= aborted_n;
            cfg_err_q <= cfg_err_n;
            valid_q   <= valid_n;
            pend_q    <= pend_n;
        end
    end

    assign desc          = layer_desc_t'(desc_bits);
    assign w_num_o       = desc.w;
    assign h_num_o       = desc.h;
    assign c_num_o       = desc.c;
    assign kernal_mode_o = desc.kernal_mode;
    assign bit_mode_o    = desc.bit_mode;

    assign cfg_err    = cfg_err_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign cur_layer  = cur_q;
    assign ctrl_valid = valid_q;
    assign dbg_state  = state;

endmodule
